// File: rtl/arbitro_vc.sv
// arbitro_vc: forwards head words from two virtual-channel source FIFOs to one
// of two destinations, selected by bit 4 of the head word. One pop per cycle at
// most; the popped word is pushed to its destination exactly one cycle later.
//
// Build option: define ARB_RR_EN for round-robin between VC0 and VC1 when both
// are eligible; left undefined, VC0 always wins a tie.
//
// state | meaning
// IDLE  | no forwarding; pops held at 0
// FWD   | forwarding; eligible source granted each cycle
module arbitro_vc (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       VC0_empty,
  input  logic       VC1_empty,
  input  logic [5:0] VC0_data,
  input  logic [5:0] VC1_data,
  input  logic       D0_almost_full,
  input  logic       D1_almost_full,
  output logic       VC0_pop,
  output logic       VC1_pop,
  output logic       D0_push,
  output logic       D1_push,
  output logic [5:0] data_out,
  output logic       idle,
  output logic [7:0] cnt_D0,
  output logic [7:0] cnt_D1
);

  typedef enum logic {IDLE = 1'b0, FWD = 1'b1} state_t;

  state_t     state_q, state_d;
  logic       d0_push_q, d0_push_d;
  logic       d1_push_q, d1_push_d;
  logic [5:0] data_out_q, data_out_d;
  logic       idle_q, idle_d;
  logic [7:0] cnt_d0_q, cnt_d0_d;
  logic [7:0] cnt_d1_q, cnt_d1_d;

  logic       elig0, elig1;
  logic       gnt0, gnt1;
  logic       pop_any;
  logic [5:0] pop_data;

`ifdef ARB_RR_EN
  // 0: VC0 wins the next tie, 1: VC1 wins the next tie
  logic       prio_q, prio_d;
`endif

  // Eligibility and grant; pops are gated by reset so nothing leaves a FIFO
  // while the block is held in reset.
  always_comb begin
    elig0 = reset && (state_q == FWD) && enable && !VC0_empty &&
            !(VC0_data[4] ? D1_almost_full : D0_almost_full);
    elig1 = reset && (state_q == FWD) && enable && !VC1_empty &&
            !(VC1_data[4] ? D1_almost_full : D0_almost_full);
`ifdef ARB_RR_EN
    if (elig0 && elig1) begin
      gnt0 = !prio_q;
    end else begin
      gnt0 = elig0;
    end
    gnt1   = elig1 && !gnt0;
    prio_d = prio_q;
    if (gnt0) prio_d = 1'b1;
    if (gnt1) prio_d = 1'b0;
`else
    gnt0 = elig0;
    gnt1 = elig1 && !elig0;
`endif
    pop_any  = gnt0 || gnt1;
    pop_data = gnt0 ? VC0_data : VC1_data;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    d0_push_d  = pop_any && !pop_data[4];
    d1_push_d  = pop_any && pop_data[4];
    data_out_d = pop_any ? pop_data : data_out_q;
    idle_d     = VC0_empty && VC1_empty && !pop_any;
    // Counters advance together with the push they count.
    cnt_d0_d   = cnt_d0_q + {7'd0, d0_push_d};
    cnt_d1_d   = cnt_d1_q + {7'd0, d1_push_d};
    case (state_q)
      IDLE: if (enable && (!VC0_empty || !VC1_empty)) state_d = FWD;
      FWD:  if (!enable || (VC0_empty && VC1_empty)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      d0_push_q  <= 1'b0;
      d1_push_q  <= 1'b0;
      data_out_q <= 6'd0;
      idle_q     <= 1'b1;
      cnt_d0_q   <= 8'd0;
      cnt_d1_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      d0_push_q  <= d0_push_d;
      d1_push_q  <= d1_push_d;
      data_out_q <= data_out_d;
      idle_q     <= idle_d;
      cnt_d0_q   <= cnt_d0_d;
      cnt_d1_q   <= cnt_d1_d;
    end
  end

`ifdef ARB_RR_EN
  // Round-robin pointer; moves only when a grant is made.
  always_ff @(posedge clk) begin
    if (!reset) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end
`endif

  assign VC0_pop  = gnt0;
  assign VC1_pop  = gnt1;
  assign D0_push  = d0_push_q;
  assign D1_push  = d1_push_q;
  assign data_out = data_out_q;
  assign idle     = idle_q;
  assign cnt_D0   = cnt_d0_q;
  assign cnt_D1   = cnt_d1_q;

endmodule

// File: tb/tb_arbitro_vc.sv
// Directed testbench for arbitro_vc: reset, single path, arbitration,
// backpressure, enable drop, reset mid-transfer and counter wrap.
module tb_arbitro_vc;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic       VC0_empty, VC1_empty;
  logic [5:0] VC0_data, VC1_data;
  logic       D0_almost_full, D1_almost_full;
  logic       VC0_pop, VC1_pop, D0_push, D1_push, idle;
  logic [5:0] data_out;
  logic [7:0] cnt_D0, cnt_D1;

  int tests = 0;
  int fails = 0;

  arbitro_vc dut (
    .clk(clk), .reset(reset), .enable(enable),
    .VC0_empty(VC0_empty), .VC1_empty(VC1_empty),
    .VC0_data(VC0_data), .VC1_data(VC1_data),
    .D0_almost_full(D0_almost_full), .D1_almost_full(D1_almost_full),
    .VC0_pop(VC0_pop), .VC1_pop(VC1_pop),
    .D0_push(D0_push), .D1_push(D1_push),
    .data_out(data_out), .idle(idle),
    .cnt_D0(cnt_D0), .cnt_D1(cnt_D1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1;
    VC0_empty = 1'b0; VC1_empty = 1'b1;
    VC0_data = 6'b010101; VC1_data = 6'b000000;
    D0_almost_full = 1'b0; D1_almost_full = 1'b0;

    // reset held three cycles with VC0 non-empty
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_pop0", {7'd0, VC0_pop}, 8'd0);
      step();
    end
    chk("rst_pop0_end", {7'd0, VC0_pop}, 8'd0);
    chk("rst_push0", {7'd0, D0_push}, 8'd0);
    chk("rst_push1", {7'd0, D1_push}, 8'd0);
    chk("rst_data", {2'd0, data_out}, 8'd0);
    chk("rst_cnt0", cnt_D0, 8'd0);
    chk("rst_cnt1", cnt_D1, 8'd0);
    chk("rst_idle", {7'd0, idle}, 8'd1);

    // single path VC0 -> D1
    reset = 1'b1;
    step();                               // IDLE -> FWD
    chk("sp_pop0", {7'd0, VC0_pop}, 8'd1);
    chk("sp_pop1", {7'd0, VC1_pop}, 8'd0);
    chk("sp_idle_busy", {7'd0, idle}, 8'd0);
    step();
    VC0_empty = 1'b1; #1;
    chk("sp_push1", {7'd0, D1_push}, 8'd1);
    chk("sp_push0", {7'd0, D0_push}, 8'd0);
    chk("sp_data", {2'd0, data_out}, 8'h15);
    chk("sp_cnt1", cnt_D1, 8'd1);
    chk("sp_pop_after", {7'd0, VC0_pop}, 8'd0);
    step();
    chk("sp_push1_off", {7'd0, D1_push}, 8'd0);
    chk("sp_data_hold", {2'd0, data_out}, 8'h15);
    chk("sp_idle_back", {7'd0, idle}, 8'd1);

    // both eligible for 4 cycles: VC0 -> D0, VC1 -> D1
    reset = 1'b0; step(); reset = 1'b1;
    VC0_data = 6'b000011; VC1_data = 6'b110000;
    VC0_empty = 1'b0; VC1_empty = 1'b0;
    step();                               // IDLE -> FWD
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
      chk("arb_pop0", {7'd0, VC0_pop}, (i % 2 == 0) ? 8'd1 : 8'd0);
      chk("arb_pop1", {7'd0, VC1_pop}, (i % 2 == 1) ? 8'd1 : 8'd0);
`else
      chk("arb_pop0", {7'd0, VC0_pop}, 8'd1);
      chk("arb_pop1", {7'd0, VC1_pop}, 8'd0);
`endif
      step();
    end
`ifdef ARB_RR_EN
    chk("arb_cnt0", cnt_D0, 8'd2);
    chk("arb_cnt1", cnt_D1, 8'd2);
`else
    chk("arb_cnt0", cnt_D0, 8'd4);
    chk("arb_cnt1", cnt_D1, 8'd0);
`endif

    // backpressure on D0: blocked VC0 must not block VC1
    D0_almost_full = 1'b1; #1;
    chk("bp_pop0", {7'd0, VC0_pop}, 8'd0);
    chk("bp_pop1", {7'd0, VC1_pop}, 8'd1);
    step();
    VC0_empty = 1'b1; VC1_empty = 1'b1; #1;
    chk("bp_push1", {7'd0, D1_push}, 8'd1);
    chk("bp_push0", {7'd0, D0_push}, 8'd0);
    chk("bp_data", {2'd0, data_out}, 8'h30);
    D0_almost_full = 1'b0;
    step();                               // FWD -> IDLE (both empty)

    // almost_full rising while a word is in flight
    VC0_empty = 1'b0;
    step();                               // IDLE -> FWD
    chk("af_pop0", {7'd0, VC0_pop}, 8'd1);
    step();
    D0_almost_full = 1'b1; #1;
    chk("af_pop0_blocked", {7'd0, VC0_pop}, 8'd0);
    chk("af_push0_inflight", {7'd0, D0_push}, 8'd1);
    step();
    chk("af_push0_off", {7'd0, D0_push}, 8'd0);
    D0_almost_full = 1'b0; #1;

    // enable dropped mid-stream
    chk("en_pop0", {7'd0, VC0_pop}, 8'd1);
    step();
    enable = 1'b0; #1;
    chk("en_pop0_drop", {7'd0, VC0_pop}, 8'd0);
    chk("en_push0_last", {7'd0, D0_push}, 8'd1);
    step();                               // FWD -> IDLE
    enable = 1'b1; #1;
    chk("en_push0_off", {7'd0, D0_push}, 8'd0);
    chk("en_state_idle", {7'd0, VC0_pop}, 8'd0);

    // reset asserted with a pop pending: word discarded
    step();                               // IDLE -> FWD
    chk("rm_pop0", {7'd0, VC0_pop}, 8'd1);
    reset = 1'b0; #1;
    chk("rm_pop0_gated", {7'd0, VC0_pop}, 8'd0);
    step();
    chk("rm_push0", {7'd0, D0_push}, 8'd0);
    chk("rm_data", {2'd0, data_out}, 8'd0);
    chk("rm_cnt0", cnt_D0, 8'd0);
    reset = 1'b1;

    // counter wrap: 256 forwards to D0
    step();                               // IDLE -> FWD
    for (int i = 0; i < 255; i++) step();
    chk("wrap_cnt255", cnt_D0, 8'd255);
    step();
    chk("wrap_cnt0", cnt_D0, 8'd0);
    chk("wrap_push0", {7'd0, D0_push}, 8'd1);
    VC0_empty = 1'b1;
    step();
    step();
    chk("wrap_idle", {7'd0, idle}, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
